lzx_74hc148: RTL and testbench
==============================

// Module: lzx_74hc148
// PURPOSE
// - Clocked 8-to-3 priority encoder modelled on the 74HC148: active-low inputs, enable input,
//   group-select and enable-output for cascading.
// - Encodes the highest-numbered active (low) input line and registers all outputs.
// - Used as an interrupt/request encoder; EO_n of one stage feeds EI_n of the next lower stage.
// PARAMETERS
// - none (fixed 8 inputs, 3-bit code)
// PORTS
// clk     input  1  system clock; all state updates on rising edge
// rst_n   input  1  asynchronous active-low reset
// din     input  8  request lines, active low; din[7] highest priority
// EI_n    input  1  enable input, active low
// dout_n  output 3  encoded index of highest-priority active input (registered)
// GS_n    output 1  group select, low when enabled and any input active (registered)
// EO_n    output 1  enable output, low when enabled and no input active (registered)
// BEHAVIOUR
// - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
// - Reset (rst_n=0, async, no clock needed): dout_n=3'b111, GS_n=1, EO_n=1; held until rst_n=1
//   and the next rising clk edge.
// - Latency: outputs reflect din/EI_n sampled at a rising clk edge, visible after that edge
//   (1 cycle). No combinational input-to-output path.
// - Next-state function, evaluated every cycle:
//   - EI_n=1 (disabled): dout_n=3'b111, GS_n=1, EO_n=1, regardless of din.
//   - EI_n=0, din=8'hFF (no request): dout_n=3'b111, GS_n=1, EO_n=0.
//   - EI_n=0, any din bit low: k = highest index with din[k]=0; dout_n = k (plain binary,
//     din[0] -> 3'b000, din[7] -> 3'b111); GS_n=0, EO_n=1.
// - Lower-index inputs are ignored whenever a higher-index input is low.
// - dout_n=3'b111 is ambiguous between "input 7 active" and "idle"; GS_n disambiguates.
// - GS_n and EO_n are never both 0.
// - X/Z on inputs: no special handling required; only legal 0/1 inputs are specified.
// - Reset asserted mid-operation forces the reset values immediately; the next post-reset
//   edge resumes normal encoding.
// - Input changes between clock edges have no effect until the next rising edge.
// TESTING
// - Reset: rst_n=0 with din=8'h00, EI_n=0 -> dout_n=111, GS_n=1, EO_n=1 without any clk edge.
// - Disabled: EI_n=1, din=8'h00 -> after next edge dout_n=111, GS_n=1, EO_n=1.
// - Idle enabled: EI_n=0, din=8'hFF -> dout_n=111, GS_n=1, EO_n=0.
// - One-hot walk: EI_n=0, din=FE,FD,FB,F7,EF,DF,BF,7F -> dout_n=000..111 in order,
//   GS_n=0, EO_n=1, each appearing one cycle after being applied.
// - Priority: EI_n=0, din=8'b0101_0101 -> dout_n=111 (din[7]); din=8'b1111_0000 -> dout_n=011.
// - Async reset mid-stream: assert rst_n during the one-hot walk -> outputs return to
//   111/1/1 at once; release -> correct encoding resumes on the next rising edge.

Source files
------------

// File: rtl/lzx_74hc148.sv
// lzx_74hc148 -- clocked 8-to-3 priority encoder in the style of the 74HC148.
//
// Encodes the highest-numbered active-low request line and registers the
// result together with the cascading outputs. Every output comes straight
// from a flop, so there is no combinational path from din/EI_n to any output.
//
// Ports
//   clk     in   1  system clock, rising-edge
//   rst_n   in   1  asynchronous active-low reset
//   din     in   8  request lines, active low, din[7] highest priority
//   EI_n    in   1  enable input, active low
//   dout_n  out  3  binary index of highest active request (registered)
//   GS_n    out  1  group select: low when enabled and a request is active
//   EO_n    out  1  enable output: low when enabled and no request is active;
//                   feeds EI_n of the next lower-priority stage
module lzx_74hc148 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       EI_n,
  output logic [2:0] dout_n,
  output logic       GS_n,
  output logic       EO_n
);

  // Packed result layout: {code[2:0], gs_n, eo_n}.
  // The idle/disabled code is 3'b111, which collides with "line 7 active";
  // gs_n is what tells them apart downstream.
  function automatic logic [4:0] encode_148(input logic [7:0] req_n, input logic en_n);
    logic [4:0] res_v;
    res_v = {3'b111, 1'b1, 1'b1};
    if (en_n == 1'b1) begin
      res_v = {3'b111, 1'b1, 1'b1};
    end else begin
      casez (req_n)
        8'b0???????: res_v = {3'd7, 1'b0, 1'b1};
        8'b10??????: res_v = {3'd6, 1'b0, 1'b1};
        8'b110?????: res_v = {3'd5, 1'b0, 1'b1};
        8'b1110????: res_v = {3'd4, 1'b0, 1'b1};
        8'b11110???: res_v = {3'd3, 1'b0, 1'b1};
        8'b111110??: res_v = {3'd2, 1'b0, 1'b1};
        8'b1111110?: res_v = {3'd1, 1'b0, 1'b1};
        8'b11111110: res_v = {3'd0, 1'b0, 1'b1};
        default:     res_v = {3'b111, 1'b1, 1'b0};
      endcase
    end
    return res_v;
  endfunction

  logic [4:0] next_s;
  logic [2:0] dout_r;
  logic       gs_r;
  logic       eo_r;

  // Next-state encoding of the sampled request lines.
  always_comb begin
    next_s = 5'b11111;
    next_s = encode_148(din, EI_n);
  end

  // Output registers; async reset returns to the disabled state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 3'b111;
      gs_r   <= 1'b1;
      eo_r   <= 1'b1;
    end else begin
      dout_r <= next_s[4:2];
      gs_r   <= next_s[1];
      eo_r   <= next_s[0];
    end
  end

  assign dout_n = dout_r;
  assign GS_n   = gs_r;
  assign EO_n   = eo_r;

endmodule

// File: tb/tb_lzx_74hc148.sv
module tb_lzx_74hc148;

  typedef struct packed {
    logic [2:0] code;
    logic       gs_n;
    logic       eo_n;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       ei_n;
  logic [2:0] dout_n;
  logic       gs_n;
  logic       eo_n;

  int   n_checks;
  int   n_fails;
  exp_t sb[$];

  lzx_74hc148 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .EI_n   (ei_n),
    .dout_n (dout_n),
    .GS_n   (gs_n),
    .EO_n   (eo_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: scan downward for the first low line.
  function automatic exp_t model(input logic [7:0] d, input logic en_n);
    exp_t e;
    e = '{code: 3'b111, gs_n: 1'b1, eo_n: 1'b1};
    if (en_n == 1'b0) begin
      e.eo_n = 1'b0;
      for (int k = 7; k >= 0; k--) begin
        if (d[k] == 1'b0 && e.gs_n == 1'b1) begin
          e.code = 3'(k);
          e.gs_n = 1'b0;
          e.eo_n = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input exp_t exp_v);
    exp_t obs;
    obs = '{code: dout_n, gs_n: gs_n, eo_n: eo_n};
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed dout_n=%b GS_n=%b EO_n=%b expected dout_n=%b GS_n=%b EO_n=%b",
             tag, obs.code, obs.gs_n, obs.eo_n, exp_v.code, exp_v.gs_n, exp_v.eo_n);
    end
  endtask

  // Drive between edges, push expectation, compare just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] d, input logic en_n, input exp_t exp_v);
    @(negedge clk);
    din  = d;
    ei_n = en_n;
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      check(tag, sb.pop_front());
    end
  endtask

  initial begin
    exp_t rst_e, dis_e, idle_e;
    logic [7:0] walk_d;
    logic [7:0] rd;
    logic       re;
    n_checks = 0;
    n_fails  = 0;
    rst_e  = '{code: 3'b111, gs_n: 1'b1, eo_n: 1'b1};
    dis_e  = rst_e;
    idle_e = '{code: 3'b111, gs_n: 1'b1, eo_n: 1'b0};

    // Reset asserted before any clock edge, with inputs that would otherwise encode.
    rst_n = 1'b1;
    din   = 8'h00;
    ei_n  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_no_clk", rst_e);
    @(posedge clk);
    #1;
    check("reset_held", rst_e);
    @(negedge clk);
    rst_n = 1'b1;

    step("disabled", 8'h00, 1'b1, dis_e);
    step("idle_enabled", 8'hFF, 1'b0, idle_e);

    for (int i = 0; i < 8; i++) begin
      walk_d = ~(8'h01 << i);
      step($sformatf("walk_%0d", i), walk_d, 1'b0,
           '{code: 3'(i), gs_n: 1'b0, eo_n: 1'b1});
    end

    step("prio_55", 8'b0101_0101, 1'b0, '{code: 3'b111, gs_n: 1'b0, eo_n: 1'b1});
    step("prio_F0", 8'b1111_0000, 1'b0, '{code: 3'b011, gs_n: 1'b0, eo_n: 1'b1});

    // Input change between edges must not reach the outputs.
    din = 8'hFE;
    #2;
    check("hold_between_edges", '{code: 3'b011, gs_n: 1'b0, eo_n: 1'b1});

    // Async reset in the middle of a walk.
    step("walk2_0", 8'hFE, 1'b0, '{code: 3'd0, gs_n: 1'b0, eo_n: 1'b1});
    step("walk2_1", 8'hFD, 1'b0, '{code: 3'd1, gs_n: 1'b0, eo_n: 1'b1});
    rst_n = 1'b0;
    #1;
    check("mid_reset", rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    step("resume_walk_2", 8'hFB, 1'b0, '{code: 3'd2, gs_n: 1'b0, eo_n: 1'b1});
    step("resume_walk_3", 8'hF7, 1'b0, '{code: 3'd3, gs_n: 1'b0, eo_n: 1'b1});

    // Random patterns against the reference model.
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      re = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      step($sformatf("rand_%0d", i), rd, re, model(rd, re));
    end

    step("idle_end", 8'hFF, 1'b0, idle_e);
    step("disabled_end", 8'h7F, 1'b1, dis_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
